// File: rtl/timer_counter.sv
// timer_counter: programmable 32-bit down-counting timer with one-shot and
// auto-reload modes, a word-addressed host register window and an interrupt
// request line for one CP0 hardware-interrupt input.
module timer_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // CTRL layout: [0] EN, [2:1] MODE, [3] IM
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;
  state_e      state_q, state_d;

  logic        en_s;
  logic        mode_reload_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        en_clr_s;
  logic        pend_set_s;
  logic        pend_fsm_clr_s;
  logic        pend_host_clr_s;
  logic        unused_din_s;

  // Only the low CTRL bits are stored; the rest of a CTRL write is dropped.
  assign unused_din_s = ^din[31:4];

  assign en_s          = ctrl_q[0];
  // Only MODE=1 auto-reloads; 0, 2 and 3 all behave as one-shot.
  assign mode_reload_s = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl_s     = we && (addr == ADDR_CTRL);
  assign wr_preset_s   = we && (addr == ADDR_PRESET);
  // In one-shot mode the host acknowledges the interrupt by writing CTRL or PRESET.
  assign pend_host_clr_s = !mode_reload_s && (wr_ctrl_s || wr_preset_s);

  // Timer FSM: next state, COUNT update and interrupt events.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    en_clr_s       = 1'b0;
    pend_set_s     = 1'b0;
    pend_fsm_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (en_s) begin
          count_d = preset_q;
          state_d = ST_CNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CNT: begin
        if (!en_s) begin
          // Stop with COUNT frozen; a restart goes back through LOAD.
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d    = ST_INT;
          pend_set_s = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (mode_reload_s) begin
          // Periodic: pending lives for exactly the INT cycle.
          state_d        = ST_LOAD;
          pend_fsm_clr_s = 1'b1;
        end else begin
          // One-shot: disarm and keep pending until the host clears it.
          state_d  = ST_IDLE;
          en_clr_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Host register writes; a host CTRL write overrides the one-shot EN auto-clear.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    if (wr_ctrl_s) begin
      ctrl_d = din[3:0];
    end else if (en_clr_s) begin
      ctrl_d = {ctrl_q[3:1], 1'b0};
    end else begin
      ctrl_d = ctrl_q;
    end
    if (wr_preset_s) begin
      preset_d = din;
    end else begin
      preset_d = preset_q;
    end
  end

  // Pending flag: clears take precedence over a same-edge set.
  always_comb begin
    pending_d = pending_q;
    if (pend_host_clr_s || pend_fsm_clr_s) begin
      pending_d = 1'b0;
    end else if (pend_set_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    // Registered form of pending & IM, computed from next-state values so it
    // tracks the flops with no extra cycle of latency.
    irq_d = pending_d & ctrl_d[3];
  end

  // State and register flops with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  // Zero-latency read mux of the register selected by addr.
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_CTRL:   dout = {28'd0, ctrl_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter. Inputs change and outputs
// are sampled 1ns after the rising edge.
module tb_timer_counter;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  timer_counter dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write lands on the next rising edge; returns 1ns after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic do_reset();
    we  = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic        bad;
    do_reset();
    rd(2'd0, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_ctrl got %h want %h", v, 32'd0); end
    rd(2'd1, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_preset got %h want %h", v, 32'd0); end
    rd(2'd2, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_count got %h want %h", v, 32'd0); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
    // Reset during an active count
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(4);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    rd(2'd2, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL midrst_count got %h want %h", v, 32'd0); end
    rd(2'd0, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL midrst_ctrl got %h want %h", v, 32'd0); end
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (irq !== 1'b0) bad = 1'b1;
      step(1);
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL midrst_irq_quiet got %b want 0", bad); end
  endtask

  task automatic test_mode0();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);          // edge E
    step(7);                  // E+7
    rd(2'd2, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL m0_count_e7 got %h want %h", v, 32'd0); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL m0_irq_e7 got %b want 0", irq); end
    step(1);                  // E+8
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL m0_irq_e8 got %b want 1", irq); end
    step(1);                  // E+9: EN auto-cleared
    rd(2'd0, v);
    n_vec++; if (v !== 32'h8) begin n_err++; $display("FAIL m0_ctrl_after got %h want %h", v, 32'h8); end
    step(3);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL m0_irq_hold got %b want 1", irq); end
    wr(2'd0, 32'h8);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL m0_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_preset_zero();
    do_reset();
    wr(2'd0, 32'h9);          // PRESET=0 from reset, edge E
    step(2);                  // E+2
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL p0_irq_e2 got %b want 0", irq); end
    step(1);                  // E+3
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL p0_irq_e3 got %b want 1", irq); end
  endtask

  task automatic test_mode1();
    logic [31:0] v;
    logic        exp;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);          // edge E; pulses at E+6, E+12, ...
    for (int k = 1; k <= 24; k++) begin
      step(1);
      exp = ((k % 6) == 0);
      n_vec++; if (irq !== exp) begin n_err++; $display("FAIL m1_irq_cyc%0d got %b want %b", k, irq, exp); end
    end
    rd(2'd0, v);
    n_vec++; if (v !== 32'hB) begin n_err++; $display("FAIL m1_ctrl got %h want %h", v, 32'hB); end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    logic        bad;
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (irq !== 1'b0) bad = 1'b1;
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL mask_irq got %b want 0", bad); end
    rd(2'd0, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL mask_ctrl got %h want %h", v, 32'h0); end
    wr(2'd0, 32'h8);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (irq !== 1'b0) bad = 1'b1;
      step(1);
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL mask_late_im got %b want 0", bad); end
  endtask

  task automatic test_stop_restart();
    logic [31:0] v;
    logic        found;
    logic        bad;
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      rd(2'd2, v);
      if (v === 32'd6) found = 1'b1;
      else step(1);
    end
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL stop_reach6 got %b want 1", found); end
    wr(2'd0, 32'h8);          // decrements once more to 5, then freezes
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (irq !== 1'b0) bad = 1'b1;
      step(1);
    end
    rd(2'd2, v);
    n_vec++; if (v !== 32'd5) begin n_err++; $display("FAIL stop_frozen got %0d want %0d", v, 5); end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL stop_irq got %b want 0", bad); end
    wr(2'd0, 32'h9);          // edge E
    step(1);                  // E+1: LOAD, not yet reloaded
    rd(2'd2, v);
    n_vec++; if (v !== 32'd5) begin n_err++; $display("FAIL restart_e1 got %0d want %0d", v, 5); end
    step(1);                  // E+2
    rd(2'd2, v);
    n_vec++; if (v !== 32'd10) begin n_err++; $display("FAIL restart_reload got %0d want %0d", v, 10); end
  endtask

  task automatic test_write_conflicts();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);          // edge E
    step(3);                  // E+3: COUNT=2
    wr(2'd1, 32'd7);          // edge E+4: COUNT=1
    rd(2'd2, v);
    n_vec++; if (v !== 32'd1) begin n_err++; $display("FAIL wc_count_undisturbed got %0d want %0d", v, 1); end
    rd(2'd1, v);
    n_vec++; if (v !== 32'd7) begin n_err++; $display("FAIL wc_preset got %0d want %0d", v, 7); end
    step(2);                  // E+6
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL wc_irq1 got %b want 1", irq); end
    step(2);                  // E+8: reloaded from new PRESET
    rd(2'd2, v);
    n_vec++; if (v !== 32'd7) begin n_err++; $display("FAIL wc_reload7 got %0d want %0d", v, 7); end
    step(7);                  // E+15
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL wc_irq_e15 got %b want 0", irq); end
    step(1);                  // E+16
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL wc_irq_e16 got %b want 1", irq); end
    wr(2'd2, 32'hDEAD_BEEF);  // E+17: INT->LOAD, COUNT still 0
    rd(2'd2, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL wc_count_write got %h want %h", v, 32'd0); end
    rd(2'd3, v);
    n_vec++; if (v !== 32'd0) begin n_err++; $display("FAIL wc_addr3 got %h want %h", v, 32'd0); end
    step(1);
    rd(2'd2, v);
    n_vec++; if (v !== 32'd7) begin n_err++; $display("FAIL wc_count_after got %0d want %0d", v, 7); end
    // Host CTRL write on the one-shot INT edge wins over EN auto-clear
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);          // edge E
    step(5);                  // E+5
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL wc_int_irq got %b want 1", irq); end
    wr(2'd0, 32'h9);          // edge E+6 = INT edge
    rd(2'd0, v);
    n_vec++; if (v !== 32'h9) begin n_err++; $display("FAIL wc_host_wins got %h want %h", v, 32'h9); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL wc_host_clear got %b want 0", irq); end
    step(4);                  // E+10
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL wc_rearm_e10 got %b want 0", irq); end
    step(1);                  // E+11
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL wc_rearm_e11 got %b want 1", irq); end
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    din  = 32'd0;
    test_reset();
    test_mode0();
    test_preset_zero();
    test_mode1();
    test_mask();
    test_stop_restart();
    test_write_conflicts();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
